// File: rtl/alu_mul_seq_pkg.sv
// alu_mul_seq_pkg -- shared ALU opcode definitions.
// The ALU that sits next to alu_mul_seq in the parent decodes these codes;
// the multiplier only ever issues ALUOP_ADD.
package alu_mul_seq_pkg;

  typedef logic [2:0] aluop_t;

  localparam aluop_t ALUOP_ADD  = 3'd0;
  localparam aluop_t ALUOP_SUB  = 3'd1;
  localparam aluop_t ALUOP_AND  = 3'd2;
  localparam aluop_t ALUOP_OR   = 3'd3;
  localparam aluop_t ALUOP_XOR  = 3'd4;
  localparam aluop_t ALUOP_SLL  = 3'd5;
  localparam aluop_t ALUOP_SRL  = 3'd6;
  localparam aluop_t ALUOP_PASS = 3'd7;

endpackage : alu_mul_seq_pkg

// File: rtl/alu_mul_seq.sv
// alu_mul_seq -- sequential 32x32 -> 32 unsigned shift-and-add multiplier.
// The accumulation add is done by an external ALU owned by the parent:
// alu_src_a = P, alu_src_b = M, alu_op_code = ADD, and alu_result returns
// P+M combinationally. One multiplier bit is consumed per RUN cycle.
// Optional feature: define MUL_SEQ_EARLY_EXIT_EN to leave RUN as soon as
// the remaining multiplier bits are all zero.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  output logic [2:0]  alu_op_code,
  input  logic [31:0] alu_result
);

  // State encodings are private to this block.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_p;     // accumulator (partial product)
  logic [31:0] r_m;     // multiplicand, shifted left each iteration
  logic [31:0] r_q;     // multiplier, shifted right each iteration
  logic [4:0]  r_cnt;   // iterations already performed

  logic        w_early_exit;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  // No set bits left in Q: further iterations cannot change P.
  assign w_early_exit = (r_q == 32'd0);
`else
  assign w_early_exit = 1'b0;
`endif

  // Control FSM and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_p     <= 32'd0;
      r_m     <= 32'd0;
      r_q     <= 32'd0;
      r_cnt   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_p     <= 32'd0;
            r_m     <= req_a;
            r_q     <= req_b;
            r_cnt   <= 5'd0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_early_exit) begin
            r_state <= S_DONE;
          end else begin
            // alu_result is P+M from the external ALU; carry-out is dropped.
            if (r_q[0]) begin
              r_p <= alu_result;
            end else begin
              r_p <= r_p;
            end
            r_m   <= {r_m[30:0], 1'b0};
            r_q   <= {1'b0, r_q[31:1]};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_DONE: begin
          // Back to IDLE only; a request cannot be taken in this same cycle.
          if (resp_ready) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registers: no path from req_* or resp_ready.
  always_comb begin
    req_ready   = (r_state == S_IDLE);
    resp_valid  = (r_state == S_DONE);
    busy        = (r_state != S_IDLE);
    resp_data   = (r_state == S_DONE) ? r_p : 32'd0;
    alu_src_a   = r_p;
    alu_src_b   = r_m;
    alu_op_code = ALUOP_ADD;
  end

endmodule : alu_mul_seq

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq -- directed and random self-checking bench for alu_mul_seq.
// Honours MUL_SEQ_EARLY_EXIT_EN when computing expected latencies.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic [31:0] alu_src_a;
  logic [31:0] alu_src_b;
  logic [2:0]  alu_op_code;
  logic [31:0] alu_result;

  int n_cmp;
  int n_fail;

  alu_mul_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op_code(alu_op_code),
    .alu_result (alu_result)
  );

  // Stand-in for the parent's ALU.
  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      ALUOP_ADD: return a + b;
      ALUOP_SUB: return a - b;
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op_code, alu_src_a, alu_src_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Cycles from accept to first resp_valid.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    int msb;
    if (b == 32'd0) return 2;
    msb = 0;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return (msb + 3 > 33) ? 33 : msb + 3;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] exp_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = {32'd0, a} * {32'd0, b};
    return full[31:0];
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"},  {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_data"},  resp_data, 32'd0);
    check({tag, "_busy"},       {31'd0, busy}, 32'd0);
    check({tag, "_src_a"},      alu_src_a, 32'd0);
    check({tag, "_src_b"},      alu_src_b, 32'd0);
    check({tag, "_op"},         {29'd0, alu_op_code}, {29'd0, ALUOP_ADD});
  endtask

  // Issue at the current negedge (block must be IDLE), wait for the
  // response, optionally stall, then complete the handshake.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int stall,
                        input string tag);
    int lat;
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat(b));
    check({tag, "_data"}, resp_data, exp_prod(a, b));
    repeat (stall) @(negedge clk);
    resp_ready = 1'b1;
    check({tag, "_ready_in_handshake"}, {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_valid_after"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int saw_valid;
    logic [31:0] ra;
    logic [31:0] rb;
    n_cmp      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    // Basic products and boundary operands.
    do_mul(32'd3, 32'd5, 0, "mul_3x5");
    check("mul_3x5_literal", exp_prod(32'd3, 32'd5), 32'd15);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_ff");
    do_mul(32'h1234_5678, 32'd0, 0, "mul_zero_b");
    do_mul(32'h8000_0000, 32'd2, 0, "mul_overflow");
    do_mul(32'd1, 32'h8000_0000, 0, "mul_msb31");
    do_mul(32'h0000_FFFF, 32'h0001_0001, 1, "mul_ffff");
    do_mul(32'd0, 32'h0000_00FF, 0, "mul_zero_a");

    // Stall in DONE for 10 cycles while pushing new requests that must be ignored.
    req_valid = 1'b1;
    req_a     = 32'h0000_1234;
    req_b     = 32'h0000_0010;
    @(negedge clk);
    req_valid = 1'b0;
    check("run_busy", {31'd0, busy}, 32'd1);
    check("run_ready", {31'd0, req_ready}, 32'd0);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("stall_latency", lat, exp_lat(32'h0000_0010));
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_a     = $urandom;
      req_b     = $urandom;
      @(negedge clk);
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_data", resp_data, 32'h0001_2340);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("stall_idle_ready", {31'd0, req_ready}, 32'd1);
    check("stall_idle_busy", {31'd0, busy}, 32'd0);
    check("stall_no_capture_src_b", alu_src_b, 32'd0);

    // Reset in the 10th RUN cycle, with req_valid and resp_ready also high.
    req_valid = 1'b1;
    req_a     = 32'h0000_0011;
    req_b     = 32'hFFFF_FFFF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_busy_before", {31'd0, busy}, 32'd1);
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_a      = 32'hCAFE_0000;
    resp_ready = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check_reset_values("midrun_reset");
    saw_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid === 1'b1) saw_valid = 1;
    end
    check("midrun_no_resp", saw_valid, 32'd0);
    do_mul(32'd7, 32'd6, 0, "mul_7x6");
    check("mul_7x6_literal", exp_prod(32'd7, 32'd6), 32'd42);

    // Back-to-back random requests with random stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 4)
        1: rb = rb >> $urandom_range(31, 0);
        2: rb = 32'd0;
        default: ;
      endcase
      do_mul(ra, rb, $urandom_range(3, 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_alu_mul_seq
